matvec_sequencer: RTL

MATVEC_SEQUENCER -- requirements
Module: matvec_sequencer

---
 rtl/matvec_sequencer_if.sv | 41 ++++
 rtl/matvec_sequencer.sv | 132 +++++++++++++
 2 files changed

// File: rtl/matvec_sequencer_if.sv
// Signal bundle between matvec_sequencer and its environment: job request,
// weight-memory read port, shared dot-product unit port and result stream.
interface matvec_sequencer_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int VECTOR_SIZE = 4,
  parameter int NUM_ROWS    = 4
);
  localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

  logic                  start;
  logic [DATA_WIDTH-1:0] in_vec [VECTOR_SIZE];
  logic [2:0]            round_mode;
  logic                  busy;
  logic                  done;
  logic                  w_rd_en;
  logic [ROW_W-1:0]      w_addr;
  logic [DATA_WIDTH-1:0] w_data [VECTOR_SIZE];
  logic [DATA_WIDTH-1:0] dp_row [VECTOR_SIZE];
  logic [DATA_WIDTH-1:0] dp_col [VECTOR_SIZE];
  logic [2:0]            dp_round_mode;
  logic [DATA_WIDTH-1:0] dp_result;
  logic [4:0]            dp_exceptions;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [ROW_W-1:0]      out_row;
  logic [4:0]            out_exc;
  logic [4:0]            sticky_exc;

  modport master (
    input  start, in_vec, round_mode, w_data, dp_result, dp_exceptions, out_ready,
    output busy, done, w_rd_en, w_addr, dp_row, dp_col, dp_round_mode,
           out_valid, out_data, out_row, out_exc, sticky_exc
  );

  modport slave (
    output start, in_vec, round_mode, w_data, dp_result, dp_exceptions, out_ready,
    input  busy, done, w_rd_en, w_addr, dp_row, dp_col, dp_round_mode,
           out_valid, out_data, out_row, out_exc, sticky_exc
  );
endinterface

// File: rtl/matvec_sequencer.sv
// Row-by-row matrix-vector job sequencer: fetches each weight row, feeds an
// external combinational dot-product unit and streams results with valid/ready.
module matvec_sequencer #(
  parameter int DATA_WIDTH  = 32,
  parameter int VECTOR_SIZE = 4,
  parameter int NUM_ROWS    = 4
) (
  input logic                clk,
  input logic                rst,
  matvec_sequencer_if.master bus
);
  localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ROWS - 1);
  localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_CAPTURE = 3'd2,
    S_EVAL    = 3'd3,
    S_OUT     = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t                state_r;
  logic [ROW_W-1:0]      row_cnt_r;
  logic [DATA_WIDTH-1:0] row_r [VECTOR_SIZE];
  logic [DATA_WIDTH-1:0] vec_r [VECTOR_SIZE];
  logic [2:0]            rm_r;
  logic                  busy_r;
  logic                  done_r;
  logic                  rd_en_r;
  logic                  valid_r;
  logic [DATA_WIDTH-1:0] out_data_r;
  logic [ROW_W-1:0]      out_row_r;
  logic [4:0]            out_exc_r;
  logic [4:0]            sticky_r;

  // Job FSM; strobes are registered on the transition into the state that owns them.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= S_IDLE;
      row_cnt_r  <= {ROW_W{1'b0}};
      rm_r       <= 3'b000;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      rd_en_r    <= 1'b0;
      valid_r    <= 1'b0;
      out_data_r <= {DATA_WIDTH{1'b0}};
      out_row_r  <= {ROW_W{1'b0}};
      out_exc_r  <= 5'b00000;
      sticky_r   <= 5'b00000;
      for (int i = 0; i < VECTOR_SIZE; i++) begin
        row_r[i] <= {DATA_WIDTH{1'b0}};
        vec_r[i] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      case (state_r)
        S_IDLE: begin
          if (bus.start) begin
            vec_r     <= bus.in_vec;
            rm_r      <= bus.round_mode;
            row_cnt_r <= {ROW_W{1'b0}};
            sticky_r  <= 5'b00000;
            busy_r    <= 1'b1;
            rd_en_r   <= 1'b1;
            state_r   <= S_FETCH;
          end else begin
            state_r   <= S_IDLE;
          end
        end
        S_FETCH: begin
          rd_en_r <= 1'b0;
          state_r <= S_CAPTURE;
        end
        S_CAPTURE: begin
          row_r   <= bus.w_data;
          state_r <= S_EVAL;
        end
        S_EVAL: begin
          out_data_r <= bus.dp_result;
          out_exc_r  <= bus.dp_exceptions;
          out_row_r  <= row_cnt_r;
          sticky_r   <= sticky_r | bus.dp_exceptions;
          valid_r    <= 1'b1;
          state_r    <= S_OUT;
        end
        S_OUT: begin
          // Results stay frozen until the consumer takes them.
          if (bus.out_ready) begin
            valid_r <= 1'b0;
            if (row_cnt_r == LAST_ROW) begin
              done_r  <= 1'b1;
              state_r <= S_DONE;
            end else begin
              row_cnt_r <= row_cnt_r + ROW_ONE;
              rd_en_r   <= 1'b1;
              state_r   <= S_FETCH;
            end
          end else begin
            state_r <= S_OUT;
          end
        end
        S_DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          rd_en_r <= 1'b0;
          valid_r <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy          = busy_r;
  assign bus.done          = done_r;
  assign bus.w_rd_en       = rd_en_r;
  assign bus.w_addr        = row_cnt_r;
  assign bus.dp_row        = row_r;
  assign bus.dp_col        = vec_r;
  assign bus.dp_round_mode = rm_r;
  assign bus.out_valid     = valid_r;
  assign bus.out_data      = out_data_r;
  assign bus.out_row       = out_row_r;
  assign bus.out_exc       = out_exc_r;
  assign bus.sticky_exc    = sticky_r;
endmodule
